mem_stage_lsu: RTL and testbench

Load/store unit that sits directly upstream of the cache memory system, between the pipeline memory stage and the cache's request port. It accepts one request at a time over a valid/ready handshake and checks alignment. It drives the cache strobes and holds them for as long as the cache stalls, then returns lane-extracted, sign- or zero-extended load data as a single-cycle response. It also keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/mem_stage_lsu.sv | 146 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - load/store unit between the pipeline memory stage and the cache request port
module mem_stage_lsu #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        storetype,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       DataIn,
    input  logic              stall,
    input  logic [31:0]       DataOut,
    output logic [15:0]       stall_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic          we_q;
    logic          uns_q;
    logic [1:0]    lane_q;
    logic [TW-1:0] to_cnt;
    logic          misaligned;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   fmt;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Lane extraction uses the latched byte offset; the cache returns the aligned word.
    always_comb begin
        byte_v = DataOut[{lane_q, 3'b000} +: 8];
        half_v = lane_q[1] ? DataOut[31:16] : DataOut[15:0];
        case (storetype)
            2'b00:   fmt = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'b01:   fmt = {{16{half_v[15] & ~uns_q}}, half_v};
            default: fmt = DataOut;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_err        <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            storetype       <= '0;
            Address         <= '0;
            DataIn          <= '0;
            stall_cnt       <= '0;
            we_q            <= 1'b0;
            uns_q           <= 1'b0;
            lane_q          <= '0;
            to_cnt          <= '0;
        end else begin
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        lane_q    <= req_addr[1:0];
                        storetype <= req_size;
                        Address   <= req_addr[ADDR_W-1:0];
                        DataIn    <= req_wdata;
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_read  <= ~req_we;
                            mem_write <= req_we;
                            to_cnt    <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!stall) begin
                        state      <= RESP;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'd0 : fmt;
                    end else begin
                        if (stall_cnt != 16'hFFFF)
                            stall_cnt <= stall_cnt + 16'd1;
                        // Abort on the TIMEOUT-th consecutive stalled edge.
                        if (to_cnt == TW'(TIMEOUT - 1)) begin
                            state      <= RESP;
                            mem_read   <= 1'b0;
                            mem_write  <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned, stall;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, DataOut;

    logic        req_ready, resp_valid, resp_misaligned, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, DataIn;
    logic [1:0]  storetype;
    logic [9:0]  Address;
    logic [15:0] stall_cnt;

    logic        t_req_ready, t_resp_valid, t_resp_misaligned, t_resp_err, t_mem_read, t_mem_write;
    logic [31:0] t_resp_rdata, t_DataIn;
    logic [1:0]  t_storetype;
    logic [9:0]  t_Address;
    logic [15:0] t_stall_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .storetype(storetype),
        .Address(Address), .DataIn(DataIn), .stall(stall), .DataOut(DataOut),
        .stall_cnt(stall_cnt)
    );

    mem_stage_lsu #(.ADDR_W(10), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(t_resp_valid),
        .resp_rdata(t_resp_rdata), .resp_misaligned(t_resp_misaligned), .resp_err(t_resp_err),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .storetype(t_storetype),
        .Address(t_Address), .DataIn(t_DataIn), .stall(stall), .DataOut(DataOut),
        .stall_cnt(t_stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; stall = 1'b0; DataOut = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", req_ready); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_misaligned, resp_err, mem_read, mem_write} !== 5'b0)
            $display("FAIL reset_ctl: got %b exp 00000", {resp_valid, resp_misaligned, resp_err, mem_read, mem_write}); else pass_cnt++;
        total_cnt++; if ({stall_cnt, Address, DataIn, resp_rdata, storetype} !== '0)
            $display("FAIL reset_data: got %h exp 0", {stall_cnt, Address, DataIn, resp_rdata, storetype}); else pass_cnt++;
    endtask

    task automatic test_load_byte();
        apply_reset();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0000_0103; DataOut = 32'h80FF_1234;
        step();
        req_valid = 1'b0;
        total_cnt++; if (mem_read !== 1'b1 || req_ready !== 1'b0) $display("FAIL lb_access: rd=%b rdy=%b exp 1 0", mem_read, req_ready); else pass_cnt++;
        total_cnt++; if (Address !== 10'h103) $display("FAIL lb_addr: got %h exp 103", Address); else pass_cnt++;
        step();
        total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80) $display("FAIL lb_resp: v=%b data=%h exp 1 ffffff80", resp_valid, resp_rdata); else pass_cnt++;
        total_cnt++; if (mem_read !== 1'b0 || stall_cnt !== 16'd0) $display("FAIL lb_after: rd=%b cnt=%0d exp 0 0", mem_read, stall_cnt); else pass_cnt++;
        step();
        total_cnt++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1)
            $display("FAIL lb_idle: v=%b data=%h rdy=%b exp 0 0 1", resp_valid, resp_rdata, req_ready); else pass_cnt++;
    endtask

    task automatic test_load_half_miss();
        int highs = 0;
        apply_reset();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b1;
        req_addr = 32'h0000_0102; DataOut = 32'h8001_7FFF; stall = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) stall = 1'b0;
            if (mem_read === 1'b1 && resp_valid === 1'b0) highs++;
            step();
        end
        total_cnt++; if (highs != 6) $display("FAIL lhu_strobe_cycles: got %0d exp 6", highs); else pass_cnt++;
        total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_8001) $display("FAIL lhu_resp: v=%b data=%h exp 1 00008001", resp_valid, resp_rdata); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 16'd5) $display("FAIL lhu_stall_cnt: got %0d exp 5", stall_cnt); else pass_cnt++;
        stall = 1'b1;
        step();
        step();
        total_cnt++; if (stall_cnt !== 16'd5) $display("FAIL lhu_stall_outside: got %0d exp 5", stall_cnt); else pass_cnt++;
        stall = 1'b0;
    endtask

    task automatic test_store_word();
        apply_reset();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_03FC; req_wdata = 32'hDEAD_BEEF; DataOut = 32'h1234_5678;
        step();
        req_valid = 1'b0;
        total_cnt++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || storetype !== 2'b10)
            $display("FAIL sw_strobe: wr=%b rd=%b st=%b exp 1 0 10", mem_write, mem_read, storetype); else pass_cnt++;
        total_cnt++; if (Address !== 10'h3FC || DataIn !== 32'hDEAD_BEEF) $display("FAIL sw_bus: addr=%h data=%h exp 3fc deadbeef", Address, DataIn); else pass_cnt++;
        step();
        total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd0 || mem_write !== 1'b0)
            $display("FAIL sw_resp: v=%b data=%h wr=%b exp 1 0 0", resp_valid, resp_rdata, mem_write); else pass_cnt++;
        step();
        total_cnt++; if (Address !== 10'h3FC || DataIn !== 32'hDEAD_BEEF || storetype !== 2'b10)
            $display("FAIL sw_hold: addr=%h data=%h st=%b exp 3fc deadbeef 10", Address, DataIn, storetype); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [2] = '{2'b10, 2'b01};
        logic [31:0] addrs [2] = '{32'h0000_0102, 32'h0000_0001};
        apply_reset();
        DataOut = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_size = sizes[i]; req_addr = addrs[i];
            step();
            req_valid = 1'b0;
            total_cnt++; if (resp_valid !== 1'b1 || resp_misaligned !== 1'b1 || resp_rdata !== 32'd0)
                $display("FAIL mis_resp_%0d: v=%b mis=%b data=%h exp 1 1 0", i, resp_valid, resp_misaligned, resp_rdata); else pass_cnt++;
            total_cnt++; if (mem_read !== 1'b0) $display("FAIL mis_strobe_%0d: got %b exp 0", i, mem_read); else pass_cnt++;
            step();
            total_cnt++; if (resp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL mis_idle_%0d: v=%b rd=%b rdy=%b exp 0 0 1", i, resp_valid, mem_read, req_ready); else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        int access_cycles = 0;
        apply_reset();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0100;
        DataOut = 32'hCAFE_F00D; stall = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (t_mem_read === 1'b1 && t_resp_valid === 1'b0) access_cycles++;
            step();
        end
        total_cnt++; if (access_cycles != 4) $display("FAIL to_access_cycles: got %0d exp 4", access_cycles); else pass_cnt++;
        total_cnt++; if (t_resp_valid !== 1'b1 || t_resp_err !== 1'b1 || t_resp_rdata !== 32'd0)
            $display("FAIL to_resp: v=%b err=%b data=%h exp 1 1 0", t_resp_valid, t_resp_err, t_resp_rdata); else pass_cnt++;
        total_cnt++; if (t_stall_cnt !== 16'd4 || t_mem_read !== 1'b0) $display("FAIL to_cnt: cnt=%0d rd=%b exp 4 0", t_stall_cnt, t_mem_read); else pass_cnt++;
        total_cnt++; if (mem_read !== 1'b1 || resp_valid !== 1'b0) $display("FAIL to_long_still_access: rd=%b v=%b exp 1 0", mem_read, resp_valid); else pass_cnt++;
        stall = 1'b0;
        step();
        total_cnt++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFE_F00D)
            $display("FAIL to_long_resp: v=%b err=%b data=%h exp 1 0 cafef00d", resp_valid, resp_err, resp_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        int seen = 0;
        apply_reset();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0000_0010; stall = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        total_cnt++; if (mem_read !== 1'b1 || stall_cnt !== 16'd1) $display("FAIL rst_mid_pre: rd=%b cnt=%0d exp 1 1", mem_read, stall_cnt); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++; if (mem_read !== 1'b0 || req_ready !== 1'b1 || stall_cnt !== 16'd0)
            $display("FAIL rst_mid_async: rd=%b rdy=%b cnt=%0d exp 0 1 0", mem_read, req_ready, stall_cnt); else pass_cnt++;
        step();
        rst = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid !== 1'b0) seen++;
            step();
        end
        total_cnt++; if (seen != 0) $display("FAIL rst_mid_no_resp: got %0d exp 0", seen); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h0000_0200; DataOut = 32'h1234_8765;
        step();
        step();
        total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_8765 || req_ready !== 1'b0)
            $display("FAIL b2b_first: v=%b data=%h rdy=%b exp 1 ffff8765 0", resp_valid, resp_rdata, req_ready); else pass_cnt++;
        step();
        total_cnt++; if (req_ready !== 1'b1 || mem_read !== 1'b0) $display("FAIL b2b_idle: rdy=%b rd=%b exp 1 0", req_ready, mem_read); else pass_cnt++;
        req_unsigned = 1'b1;
        step();
        req_valid = 1'b0;
        total_cnt++; if (mem_read !== 1'b1) $display("FAIL b2b_second_accept: rd=%b exp 1", mem_read); else pass_cnt++;
        step();
        total_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_8765) $display("FAIL b2b_second: v=%b data=%h exp 1 00008765", resp_valid, resp_rdata); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_miss();
        test_store_word();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
